tw_seed_gen: RTL

- Upstream feeder for the stage-0 twiddle buffer of the radix-16 NTT twiddle ROM.
- Takes a seed w0 and a step ws, and computes w0, w0·ws, w0·ws², w0·ws³ mod p, where p = 2^64 − 2^32 + 1.
- Streams the four words as one contiguous burst on horizontal_tf_in with ROM0_w high, matching the ROM's 4-entry horizontal write counter.
- Contains a pipelined Goldilocks modular multiplier and a small control FSM.

---
 rtl/tw_seed_gen_if.sv | 29 ++
 rtl/tw_seed_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_seed_gen_if.sv
// Request/burst interface between a twiddle-seed client and tw_seed_gen.
// The chained-seed signals exist only when TWG_CHAIN_EN is defined.
interface tw_seed_gen_if #(
    parameter int P_WIDTH  = 64,
    parameter int CW_WIDTH = 2
);
    logic                start;
    logic [P_WIDTH-1:0]  seed_in;
    logic [P_WIDTH-1:0]  step_in;
    logic                busy;
    logic                ROM0_w;
    logic [P_WIDTH-1:0]  horizontal_tf_in;
    logic                done;
    logic [CW_WIDTH-1:0] word_idx;
`ifdef TWG_CHAIN_EN
    logic                start_cont;
    logic [P_WIDTH-1:0]  next_seed;

    modport master (output start, start_cont, seed_in, step_in,
                    input  busy, ROM0_w, horizontal_tf_in, done, word_idx, next_seed);
    modport slave  (input  start, start_cont, seed_in, step_in,
                    output busy, ROM0_w, horizontal_tf_in, done, word_idx, next_seed);
`else
    modport master (output start, seed_in, step_in,
                    input  busy, ROM0_w, horizontal_tf_in, done, word_idx);
    modport slave  (input  start, seed_in, step_in,
                    output busy, ROM0_w, horizontal_tf_in, done, word_idx);
`endif
endinterface

// File: rtl/tw_seed_gen.sv
// Twiddle seed generator: computes w0*ws^k mod p (Goldilocks) and streams a burst to ROM0.
// Optional macro TWG_CHAIN_EN adds next_seed/start_cont for chaining bursts.

module tw_gold_mul #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vld,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_vld,
    output logic [63:0] o_res
);
    localparam logic [63:0] LP_P   = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] LP_EPS = 64'h0000_0000_FFFF_FFFF;

    logic [127:0] r_prod;
    logic         r_v1;
    logic [63:0]  r_res;
    logic         r_vf;

    logic [63:0]  w_lo, w_diff, w_t0, w_t1, w_t0_s, w_t1_s, w_adj, w_fin;
    logic [31:0]  w_hl, w_hh;
    logic [64:0]  w_sum;
    logic         w_borrow, w_v2;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_vf <= 1'b0;
        end else begin
            r_v1 <= i_vld;
            r_vf <= w_v2;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide when they matter.
    always_ff @(posedge clk) begin
        r_prod <= {64'd0, i_a} * {64'd0, i_b};
        r_res  <= w_fin;
    end

    assign w_lo     = r_prod[63:0];
    assign w_hl     = r_prod[95:64];
    assign w_hh     = r_prod[127:96];
    // 2^96 = -1 and 2^64 = 2^32-1 (mod p); a wrap of either sum is worth 2^32-1.
    assign w_borrow = (w_lo < {32'd0, w_hh});
    assign w_diff   = w_lo - {32'd0, w_hh};
    assign w_t0     = w_borrow ? (w_diff - LP_EPS) : w_diff;
    assign w_t1     = {w_hl, 32'd0} - {32'd0, w_hl};

    generate
        if (MUL_LAT >= 3) begin : g_stage2
            logic [63:0] r_t0, r_t1;
            logic        r_v2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_v2 <= 1'b0;
                else     r_v2 <= r_v1;
            end
            always_ff @(posedge clk) begin
                r_t0 <= w_t0;
                r_t1 <= w_t1;
            end
            assign w_t0_s = r_t0;
            assign w_t1_s = r_t1;
            assign w_v2   = r_v2;
        end else begin : g_stage2_bypass
            assign w_t0_s = w_t0;
            assign w_t1_s = w_t1;
            assign w_v2   = r_v1;
        end
    endgenerate

    assign w_sum = {1'b0, w_t0_s} + {1'b0, w_t1_s};
    assign w_adj = w_sum[64] ? (w_sum[63:0] + LP_EPS) : w_sum[63:0];
    assign w_fin = (w_adj >= LP_P) ? (w_adj - LP_P) : w_adj;

    generate
        if (MUL_LAT > 3) begin : g_delay
            localparam int LP_D = MUL_LAT - 3;
            logic [63:0] r_d [LP_D];
            logic [LP_D-1:0] r_dv;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dv <= '0;
                end else begin
                    r_dv[0] <= r_vf;
                    for (int i = 1; i < LP_D; i++) r_dv[i] <= r_dv[i-1];
                end
            end
            always_ff @(posedge clk) begin
                r_d[0] <= r_res;
                for (int i = 1; i < LP_D; i++) r_d[i] <= r_d[i-1];
            end
            assign o_vld = r_dv[LP_D-1];
            assign o_res = r_d[LP_D-1];
        end else begin : g_no_delay
            assign o_vld = r_vf;
            assign o_res = r_res;
        end
    endgenerate
endmodule

module tw_seed_gen #(
    parameter int P_WIDTH   = 64,
    parameter int NUM_WORDS = 4,
    parameter int MUL_LAT   = 3,
    parameter int CW_WIDTH  = 2
) (
    input  logic          CLK,
    input  logic          rst,
    tw_seed_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [CW_WIDTH-1:0] LP_IDX_ONE  = CW_WIDTH'(1);
    localparam logic [CW_WIDTH-1:0] LP_IDX_LAST = CW_WIDTH'(NUM_WORDS - 1);
    localparam logic [CW_WIDTH:0]   LP_CNT_ONE  = (CW_WIDTH + 1)'(1);
    localparam logic [CW_WIDTH:0]   LP_CNT_END  = (CW_WIDTH + 1)'(NUM_WORDS);

    state_t              r_state, w_next_state;
    logic [P_WIDTH-1:0]  r_buf [NUM_WORDS];
    logic [P_WIDTH-1:0]  r_step;
    logic [CW_WIDTH-1:0] r_wr_idx;
    logic [CW_WIDTH:0]   r_emit_cnt;
    logic                r_rom_w, r_done;
    logic [P_WIDTH-1:0]  r_tf;
    logic [CW_WIDTH-1:0] r_word_idx;

    logic                w_go, w_load, w_issue, w_buf_wr, w_emit, w_finish, w_mul_vld;
    logic [P_WIDTH-1:0]  w_seed_sel, w_mul_a, w_mul_b, w_mul_res;

`ifdef TWG_CHAIN_EN
    logic [P_WIDTH-1:0]  r_next_seed;
    logic                w_ns_wr;

    assign w_go          = bus.start | bus.start_cont;
    assign w_seed_sel    = bus.start_cont ? r_next_seed : bus.seed_in;
    assign bus.next_seed = r_next_seed;
`else
    assign w_go          = bus.start;
    assign w_seed_sel    = bus.seed_in;
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        w_mul_a      = w_mul_res;
        w_mul_b      = r_step;
        w_buf_wr     = 1'b0;
        w_emit       = 1'b0;
        w_finish     = 1'b0;
`ifdef TWG_CHAIN_EN
        w_ns_wr      = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_load       = 1'b1;
                    w_issue      = 1'b1;
                    w_mul_a      = w_seed_sel;
                    w_mul_b      = bus.step_in;
                    w_next_state = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_vld) begin
                    w_buf_wr = 1'b1;
                    if (r_wr_idx == LP_IDX_LAST) begin
                        w_next_state = S_EMIT;
`ifdef TWG_CHAIN_EN
                        // One extra product for the next seed runs underneath EMIT.
                        w_issue      = 1'b1;
`endif
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            S_EMIT: begin
`ifdef TWG_CHAIN_EN
                w_ns_wr = w_mul_vld;
`endif
                if (r_emit_cnt == LP_CNT_END) begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= '0;
            r_step     <= '0;
            r_wr_idx   <= '0;
            r_emit_cnt <= '0;
            r_rom_w    <= 1'b0;
            r_done     <= 1'b0;
            r_tf       <= '0;
            r_word_idx <= '0;
`ifdef TWG_CHAIN_EN
            r_next_seed <= '0;
`endif
        end else begin
            r_rom_w <= w_emit;
            r_done  <= w_finish;
            if (w_load) begin
                r_buf[0]   <= w_seed_sel;
                r_step     <= bus.step_in;
                r_wr_idx   <= LP_IDX_ONE;
                r_emit_cnt <= '0;
            end
            if (w_buf_wr) begin
                r_buf[r_wr_idx] <= w_mul_res;
                r_wr_idx        <= r_wr_idx + LP_IDX_ONE;
            end
            if (w_emit) begin
                r_tf       <= r_buf[r_emit_cnt[CW_WIDTH-1:0]];
                r_word_idx <= r_emit_cnt[CW_WIDTH-1:0];
                r_emit_cnt <= r_emit_cnt + LP_CNT_ONE;
            end
`ifdef TWG_CHAIN_EN
            if (w_ns_wr) r_next_seed <= w_mul_res;
`endif
        end
    end

    tw_gold_mul #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk   (CLK),
        .rst   (rst),
        .i_vld (w_issue),
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .o_vld (w_mul_vld),
        .o_res (w_mul_res)
    );

    assign bus.busy             = (r_state != S_IDLE);
    assign bus.ROM0_w           = r_rom_w;
    assign bus.horizontal_tf_in = r_tf;
    assign bus.done             = r_done;
    assign bus.word_idx         = r_word_idx;
endmodule
